step_scheduler: RTL

STEP_SCHEDULER -- requirements
Module: step_scheduler

---
 rtl/seq_pkg.sv | 12 +
 rtl/seq_divider.sv | 75 +++++++
 rtl/step_scheduler.sv | 119 +++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared constants and divider state encoding for the step sequencer.
package seq_pkg;
  localparam int BPM_MAX            = 600;
  localparam int NUM_STEPS_DEF      = 16;
  localparam int STEPS_PER_BEAT_DEF = 4;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'd0,
    DIV_DIVIDE = 2'd1,
    DIV_DONE   = 2'd2
  } div_state_t;
endpackage

// File: rtl/seq_divider.sv
// Restoring divider: one quotient bit per cycle for DIV_W cycles, then a single DONE cycle.
module seq_divider
  import seq_pkg::*;
#(
  parameter int DIV_W = 30
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] quotient,
  output logic             done,
  output logic             busy
);
  localparam int CNT_W = $clog2(DIV_W);

  div_state_t       state, state_nx;
  logic [CNT_W-1:0] bit_cnt;
  logic [DIV_W-1:0] rem, dvsr;
  logic [DIV_W:0]   rem_sh, rem_sub;
  logic             ge;

  // Partial remainder shifted left with the next dividend bit, and trial subtraction.
  always_comb begin
    rem_sh  = {rem, quotient[DIV_W-1]};
    ge      = rem_sh >= {1'b0, dvsr};
    rem_sub = rem_sh - {1'b0, dvsr};
  end

  // Next-state logic: IDLE -> DIVIDE (DIV_W cycles) -> DONE (1 cycle) -> IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      DIV_IDLE:   if (start) state_nx = DIV_DIVIDE;
      DIV_DIVIDE: if (bit_cnt == CNT_W'(DIV_W-1)) state_nx = DIV_DONE;
      DIV_DONE:   state_nx = DIV_IDLE;
      default:    state_nx = DIV_IDLE;
    endcase
  end

  // State register plus registered done/busy flags decoded from the next state.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state <= DIV_IDLE;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= (state_nx == DIV_DONE);
      busy  <= (state_nx != DIV_IDLE);
    end
  end

  // Datapath: operands captured on leaving IDLE so later input changes cannot corrupt the result.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      quotient <= '0;
      rem      <= '0;
      dvsr     <= '0;
      bit_cnt  <= '0;
    end else if (state == DIV_IDLE) begin
      if (start) begin
        quotient <= dividend;
        dvsr     <= divisor;
        rem      <= '0;
        bit_cnt  <= '0;
      end
    end else if (state == DIV_DIVIDE) begin
      quotient <= {quotient[DIV_W-2:0], ge};
      rem      <= ge ? DIV_W'(rem_sub) : DIV_W'(rem_sh);
      bit_cnt  <= bit_cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/step_scheduler.sv
// Tempo-driven step clock: converts committed BPM into a step period and emits step/beat ticks.
module step_scheduler
  import seq_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int STEPS_PER_BEAT = STEPS_PER_BEAT_DEF,
  parameter int NUM_STEPS      = NUM_STEPS_DEF,
  parameter int DIV_W          = 30
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic [9:0] bpm,
  input  logic       bpm_set,
  input  logic       run,
  input  logic       restart,
  output logic       step_tick,
  output logic       beat_tick,
  output logic [3:0] step_idx,
  output logic       busy
);
  // Clock cycles per minute divided by steps per beat; period = K / bpm.
  localparam longint     K_L = (longint'(CLK_HZ) * 60) / longint'(STEPS_PER_BEAT);
  localparam logic [DIV_W-1:0] K = DIV_W'(K_L);

  logic [9:0]       bpm_c, last_bpm, op_bpm;
  logic             div_start, div_done, zero_clr;
  logic [DIV_W-1:0] quotient, pending_period, active_period, cnt, cnt_nx;
  logic             pending_valid, active_valid, run_armed;
  logic             tick_nx, beat_nx, wrap;
  logic [3:0]       idx_nx;

  // Clamp and request decode; zero tempo is handled without the divider.
  always_comb begin
    bpm_c     = (bpm > 10'(BPM_MAX)) ? 10'(BPM_MAX) : bpm;
    zero_clr  = bpm_set && (bpm == 10'd0);
    div_start = bpm_set && !busy && (bpm_c != 10'd0) && (bpm_c != last_bpm);
  end

  seq_divider #(.DIV_W(DIV_W)) u_div (
    .Clock    (Clock),
    .nReset   (nReset),
    .start    (div_start),
    .dividend (K),
    .divisor  (DIV_W'(bpm_c)),
    .quotient (quotient),
    .done     (div_done),
    .busy     (busy)
  );

  // Step counter next state: restart beats wrap; a fresh run (or newly valid period) sounds at once.
  always_comb begin
    cnt_nx  = cnt;
    idx_nx  = step_idx;
    tick_nx = 1'b0;
    wrap    = (cnt == active_period - DIV_W'(1));
    if (restart) begin
      cnt_nx  = '0;
      idx_nx  = '0;
      tick_nx = run && active_valid && !step_tick;
    end else if (run && active_valid) begin
      if (!run_armed) begin
        cnt_nx  = '0;
        tick_nx = 1'b1;
      end else if (wrap) begin
        cnt_nx  = '0;
        idx_nx  = (step_idx == 4'(NUM_STEPS-1)) ? 4'd0 : step_idx + 4'd1;
        tick_nx = 1'b1;
      end else begin
        cnt_nx  = cnt + DIV_W'(1);
      end
    end
    beat_nx = tick_nx && ((int'(idx_nx) % STEPS_PER_BEAT) == 0);
  end

  // Period bookkeeping: new periods wait in pending until a step boundary (or idle) to avoid mid-step changes.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      last_bpm       <= '0;
      op_bpm         <= '0;
      pending_period <= '0;
      active_period  <= '0;
      pending_valid  <= 1'b0;
      active_valid   <= 1'b0;
    end else if (zero_clr) begin
      last_bpm      <= '0;
      pending_valid <= 1'b0;
      active_valid  <= 1'b0;
    end else begin
      if (div_start) op_bpm <= bpm_c;
      if (pending_valid && (tick_nx || !run || !active_valid)) begin
        active_period <= pending_period;
        active_valid  <= 1'b1;
        pending_valid <= 1'b0;
      end
      if (div_done) begin
        pending_period <= quotient;
        pending_valid  <= 1'b1;
        last_bpm       <= op_bpm;
      end
    end
  end

  // Step counter and registered tick outputs.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      cnt       <= '0;
      step_idx  <= '0;
      step_tick <= 1'b0;
      beat_tick <= 1'b0;
      run_armed <= 1'b0;
    end else begin
      cnt       <= cnt_nx;
      step_idx  <= idx_nx;
      step_tick <= tick_nx;
      beat_tick <= beat_nx;
      run_armed <= run && active_valid;
    end
  end
endmodule
